strand_loader: RTL and testbench

//  Front-end stage feeding the forward/backward recursion engine.
//  - Deserialises one received (post-IDS) DNA strand, arriving one binary symbol per beat, into a packed strand word.
//  - Launches the recursion with a one-cycle start pulse, then holds the strand stable until the recursion reports done.
//  - Re-arms for the next frame once done is seen.

---
 rtl/dna_pkg.sv | 22 ++
 rtl/strand_loader_if.sv | 15 +
 rtl/strand_shift_reg.sv | 47 ++++
 rtl/strand_loader.sv | 126 ++++++++++++
 tb/tb_strand_loader.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dna_pkg.sv
// Shared types and defaults for the DNA strand recursion datapath.
// Contents: loader_state_t (strand_loader FSM states), len_w() helper for
// length-field widths, and default DATA_WIDTH / N / n / MAX_DEL values.
package dna_pkg;

  localparam int unsigned DNA_DATA_WIDTH = 32;
  localparam int unsigned DNA_N          = 16;
  localparam int unsigned DNA_CW_LEN     = 10;
  localparam int unsigned DNA_MAX_DEL    = 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } loader_state_t;

  // Width of a field able to hold any count 0..width
  function automatic int unsigned len_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/strand_loader_if.sv
// Symbol stream into the strand loader: one received binary symbol per beat.
// Signals: s_valid (symbol valid), s_ready (loader accepts), s_bit (symbol),
// s_last (final symbol of the strand).
// Modports: master drives symbols, slave (the loader) drives s_ready.
interface strand_loader_if;

  logic s_valid;
  logic s_ready;
  logic s_bit;
  logic s_last;

  modport master (output s_valid, output s_bit, output s_last, input s_ready);
  modport slave  (input s_valid, input s_bit, input s_last, output s_ready);

endinterface

// File: rtl/strand_shift_reg.sv
// Strand accumulator: writes symbol k at bit k, counts kept symbols,
// saturates at N and flags overflow once a symbol had to be dropped.
// Ports: clk, rst (sync, active-high), wr (accepted beat), sym (symbol),
// clr (start a new frame), strand (packed word), cnt (symbols kept),
// overflow (sticky until clr/rst).
module strand_shift_reg
  import dna_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DNA_DATA_WIDTH,
  parameter int unsigned N          = DNA_N
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr,
  input  logic                          sym,
  input  logic                          clr,
  output logic [DATA_WIDTH-1:0]         strand,
  output logic [len_w(DATA_WIDTH)-1:0]  cnt,
  output logic                          overflow
);

  localparam int unsigned LEN_W = len_w(DATA_WIDTH);
  localparam logic [LEN_W-1:0] N_CNT = LEN_W'(N);

  // Bits at and above cnt are always zero, so an OR sets symbol cnt in place
  always_ff @(posedge clk) begin
    if (rst) begin
      strand   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      strand   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (wr) begin
      if (cnt < N_CNT) begin
        if (sym) begin
          strand <= strand | (DATA_WIDTH'(1) << cnt);
        end
        cnt <= cnt + LEN_W'(1);
      end else begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/strand_loader.sv
// Front-end of the forward/backward recursion: deserialises one received
// strand into a packed word, launches the recursion with a one-cycle pulse
// and holds the word stable until the engine signals done.
// Ports: clk, rst (sync, active-high), s (symbol stream, slave side),
// rec_done (engine done level), strand, strand_len, start_recursion, busy,
// overflow, len_err.
// Option macro STRAND_LEN_CHECK_EN: frames whose final length is above N or
// below n-MAX_DEL pulse len_err and are discarded without a launch;
// otherwise len_err stays 0 and every frame is launched.
module strand_loader
  import dna_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DNA_DATA_WIDTH,
  parameter int unsigned N          = DNA_N,
  parameter int unsigned n          = DNA_CW_LEN,
  parameter int unsigned MAX_DEL    = DNA_MAX_DEL
) (
  input  logic                          clk,
  input  logic                          rst,
  strand_loader_if.slave                s,
  input  logic                          rec_done,
  output logic [DATA_WIDTH-1:0]         strand,
  output logic [len_w(DATA_WIDTH)-1:0]  strand_len,
  output logic                          start_recursion,
  output logic                          busy,
  output logic                          overflow,
  output logic                          len_err
);

  localparam int unsigned LEN_W = len_w(DATA_WIDTH);

  if (N > DATA_WIDTH) begin : g_bad_n
    $error("strand_loader: N exceeds DATA_WIDTH");
  end
  if (int'(n) - int'(MAX_DEL) > int'(N)) begin : g_bad_min_len
    $error("strand_loader: n-MAX_DEL exceeds N, no frame could be kept whole");
  end

  loader_state_t state, state_next;
  logic          rec_done_q;
  logic          beat;
  logic          rise;
  logic          frame_bad;
  logic          wr;
  logic          clr;
  logic          len_fail;

  assign beat = s.s_valid && (state == LOAD);
  assign rise = rec_done && !rec_done_q;

`ifdef STRAND_LEN_CHECK_EN
  localparam logic [LEN_W-1:0] N_CNT = LEN_W'(N);
  // Length after this beat: cnt+1 below N, otherwise the frame overflows (N+1)
  assign frame_bad = overflow || (strand_len == N_CNT) ||
                     (int'(strand_len) + 1 < int'(n) - int'(MAX_DEL));
`else
  assign frame_bad = 1'b0;
`endif

  strand_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .sym      (s.s_bit),
    .clr      (clr),
    .strand   (strand),
    .cnt      (strand_len),
    .overflow (overflow)
  );

  // Next state and datapath controls
  always_comb begin
    state_next = state;
    wr         = 1'b0;
    clr        = 1'b0;
    len_fail   = 1'b0;
    unique case (state)
      LOAD: begin
        if (beat) begin
          wr = 1'b1;
          if (s.s_last) begin
            if (frame_bad) begin
              clr      = 1'b1;
              len_fail = 1'b1;
            end else begin
              state_next = LAUNCH;
            end
          end
        end
      end
      LAUNCH: state_next = WAIT;
      WAIT: begin
        // Only a fresh rising edge counts; a done level left over from the
        // previous frame is still high here and is ignored
        if (rise) begin
          state_next = LOAD;
          clr        = 1'b1;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // State register and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= LOAD;
      rec_done_q      <= 1'b0;
      s.s_ready       <= 1'b1;
      start_recursion <= 1'b0;
      busy            <= 1'b0;
      len_err         <= 1'b0;
    end else begin
      state           <= state_next;
      rec_done_q      <= rec_done;
      s.s_ready       <= (state_next == LOAD);
      start_recursion <= (state_next == LAUNCH);
      busy            <= (state_next != LOAD);
      len_err         <= len_fail;
    end
  end

endmodule

// File: tb/tb_strand_loader.sv
module tb_strand_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned NN = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned MD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rec_done = 1'b0;
  logic [DW-1:0] strand;
  logic [5:0]    strand_len;
  logic          start_recursion;
  logic          busy;
  logic          overflow;
  logic          len_err;

  strand_loader_if sif ();

  strand_loader #(
    .DATA_WIDTH (DW),
    .N          (NN),
    .n          (CW),
    .MAX_DEL    (MD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s               (sif),
    .rec_done        (rec_done),
    .strand          (strand),
    .strand_len      (strand_len),
    .start_recursion (start_recursion),
    .busy            (busy),
    .overflow        (overflow),
    .len_err         (len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outcome of one frame: either a launch or a length-error pulse
  typedef struct {
    bit          err;
    logic [31:0] strand;
    int          len;
    bit          ov;
    int          cyc;
  } exp_t;

  exp_t q[$];

  // Monitor: pops an expectation whenever the DUT launches or rejects a frame,
  // and checks the strand stays frozen while busy
  logic [31:0] held_strand = '0;
  int          held_len = 0;
  bit          prev_start = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (start_recursion || len_err) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_outcome: start=%0b len_err=%0b with nothing expected (cycle %0d)",
                   start_recursion, len_err, cyc);
        end else begin
          e = q.pop_front();
          check("outcome_len_err", 32'(len_err), 32'(e.err));
          check("outcome_start", 32'(start_recursion), 32'(!e.err));
          check("outcome_cycle", 32'(cyc), 32'(e.cyc));
          if (!e.err) begin
            check("launch_strand", strand, e.strand);
            check("launch_len", 32'(strand_len), 32'(e.len));
            check("launch_overflow", 32'(overflow), 32'(e.ov));
            check("start_one_cycle", 32'(prev_start), 32'd0);
            held_strand = e.strand;
            held_len    = e.len;
          end
        end
      end else if (busy) begin
        check("strand_hold", strand, held_strand);
        check("len_hold", 32'(strand_len), 32'(held_len));
      end
      prev_start = start_recursion;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic wait_cycles(input int k, input bit junk);
    repeat (k) begin
      @(posedge clk); #1;
      sif.s_valid = junk;
      sif.s_bit   = 1'($urandom);
      sif.s_last  = 1'($urandom);
    end
  endtask

  task automatic send_beat(input bit b, input bit last);
    int waited = 0;
    sif.s_valid = 1'b1;
    sif.s_bit   = b;
    sif.s_last  = last;
    @(negedge clk);
    while (!sif.s_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!sif.s_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: s_ready low for %0d cycles in a frame", waited);
    end
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(sif.s_ready), 32'd1);
    check({tag, "_strand"}, strand, 32'd0);
    check({tag, "_len"}, 32'(strand_len), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // Reference model: first N symbols kept at bit k, rest dropped with overflow
  function automatic exp_t model(input bit bits[$]);
    exp_t e;
    int   total = bits.size();
    int   keep  = (total > int'(NN)) ? int'(NN) : total;
    e.strand = '0;
    for (int k = 0; k < keep; k++) begin
      if (bits[k]) e.strand = e.strand | (32'd1 << k);
    end
    e.len = keep;
    e.ov  = (total > int'(NN));
`ifdef STRAND_LEN_CHECK_EN
    e.err = (total > int'(NN)) || (total < int'(CW) - int'(MD));
`else
    e.err = 1'b0;
`endif
    e.cyc = 0;
    return e;
  endfunction

  task automatic send_frame(input bit bits[$], output exp_t e);
    e = model(bits);
    for (int i = 0; i < bits.size(); i++) begin
      if (i > 0 && $urandom_range(3) == 0) begin
        sif.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_beat(bits[i], i == bits.size() - 1);
    end
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic run_frame(input bit bits[$], input int hold, input bit junk);
    exp_t e;
    send_frame(bits, e);
    if (e.err) begin
      @(negedge clk);
      check("reject_ready", 32'(sif.s_ready), 32'd1);
      check("reject_busy", 32'(busy), 32'd0);
      check("reject_strand", strand, 32'd0);
      @(negedge clk);
      check("reject_pulse_width", 32'(len_err), 32'd0);
      @(posedge clk); #1;
      return;
    end
    sif.s_valid = junk;
    wait_cycles(hold + 1, junk);
    rec_done = 1'b0;
    wait_cycles(1 + int'($urandom_range(3)), junk);
    @(negedge clk);
    check("held_until_done_edge", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rec_done = 1'b1;
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
    @(negedge clk);
    check_cleared("after_done");
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    sif.s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_cleared("after_reset");
    check("after_reset_start", 32'(start_recursion), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rand_bits(input int len, output bit b[$]);
    b = {};
    for (int i = 0; i < len; i++) b.push_back(1'($urandom));
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1);
  end

  initial begin
    bit   b[$];
    exp_t e;
    sif.s_valid = 1'b0;
    sif.s_bit   = 1'b0;
    sif.s_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    check("reset_start", 32'(start_recursion), 32'd0);
    check("reset_len_err", 32'(len_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed frame: 1,0,1,1,0,0,1,0,1,1
    b = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1};
    run_frame(b, 0, 1'b0);

    // Done held high from the previous frame through LAUNCH and early WAIT
    rand_bits(12, b);
    run_frame(b, 4, 1'b0);

    // Overlong frame: 18 symbols, only 16 kept
    rand_bits(18, b);
    run_frame(b, 1, 1'b0);

    // Reset mid-frame, then a clean frame must start from symbol 0
    for (int i = 0; i < 5; i++) send_beat(1'b1, 1'b0);
    reset_pulse();
    rand_bits(11, b);
    run_frame(b, 0, 1'b0);

    // Reset while waiting for the engine
    rand_bits(12, b);
    send_frame(b, e);
    wait_cycles(3, 1'b0);
    reset_pulse();
    rand_bits(9, b);
    run_frame(b, 2, 1'b0);

    // Back-to-back frames with s_valid held high through LAUNCH/WAIT
    for (int f = 0; f < 4; f++) begin
      rand_bits(8 + f, b);
      run_frame(b, f, 1'b1);
    end

`ifdef STRAND_LEN_CHECK_EN
    // Too short: 7 symbols against a minimum of n-MAX_DEL = 8
    rand_bits(7, b);
    run_frame(b, 0, 1'b0);
`endif

    // Random frames
    for (int f = 0; f < 40; f++) begin
      rand_bits(int'($urandom_range(1, 20)), b);
      run_frame(b, int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
